serial_operand_tx: RTL

//  Parallel-to-serial operand transmitter: feeds the 4-bit serial adder's serial

---
 rtl/serial_operand_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_operand_tx.sv
// serial_operand_tx: parallel-to-serial operand transmitter for the 4-bit
// serial adder. Each accepted word clears the adder carry for one cycle,
// shifts N bits LSB-first with shift_ctrl high, then pulses done.
// Optional feature macro: SERIAL_TX_WORDCNT_EN adds an 8-bit completed-word
// counter on port word_cnt.
module serial_operand_tx #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  output logic         so,
  output logic         shift_ctrl,
  output logic         carry_clr_n,
  output logic         done
`ifdef SERIAL_TX_WORDCNT_EN
  ,
  output logic [7:0]   word_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state, state_nxt;
  logic [N-1:0]     sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             so_nxt, shift_nxt, clrn_nxt, done_nxt, ready_nxt;

  // State, datapath and registered outputs; clear aborts any word in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      so          <= 1'b0;
      shift_ctrl  <= 1'b0;
      carry_clr_n <= 1'b1;
      done        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      cnt         <= cnt_nxt;
      so          <= so_nxt;
      shift_ctrl  <= shift_nxt;
      carry_clr_n <= clrn_nxt;
      done        <= done_nxt;
      load_ready  <= ready_nxt;
    end
  end

  // Next state and datapath; outputs are decoded from the next state so the
  // registered outputs line up with the state they belong to. In SHIFT the
  // invariant so == sreg[0] holds, so the next bit is sreg_nxt[0].
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          sreg_nxt  = load_data;
          cnt_nxt   = '0;
          state_nxt = CLR;
        end
      end
      CLR: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sreg_nxt = sreg >> 1;
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    so_nxt    = (state_nxt == SHIFT) && sreg_nxt[0];
    shift_nxt = (state_nxt == SHIFT);
    clrn_nxt  = (state_nxt != CLR);
    done_nxt  = (state_nxt == DONE);
    ready_nxt = (state_nxt == IDLE);
  end

`ifdef SERIAL_TX_WORDCNT_EN
  // Count completed words; aborted words never reach DONE so are not counted.
  always_ff @(posedge clock) begin
    if (clear) begin
      word_cnt <= '0;
    end else if (state == DONE) begin
      word_cnt <= word_cnt + 8'd1;
    end
  end
`endif

endmodule
